dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
Two-port arbiter that shares the single data memory between the pipeline memory stage (port A) and a secondary requester such as a program/data loader or debug unit (port B). Port A has default priority. A wait counter guarantees port B service within MAX_WAIT cycles by stalling the pipeline for one slot. The block drives the data memory's write-enable/address/write-data and returns read data to the owning port with one-cycle latency.

Parameters:
DW, 22, data width (matches pipeline word)
AW, 22, address width (ALU result used as address)
MAX_WAIT, 4, cycles port B may be denied before a forced grant; legal range 1..15

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-low
a_req  in  1  pipeline requests an access this cycle
a_we  in  1  1 = write, 0 = read
a_addr  in  AW  pipeline address
a_wdata  in  DW  pipeline write data
a_gnt  out  1  access for A issued this cycle
a_stall  out  1  a_req & ~a_gnt; freezes pipeline stages up to and including memory
a_rvalid  out  1  read data for A valid this cycle
a_rdata  out  DW  read data for A
b_req, b_we, b_addr, b_wdata  in  1/1/AW/DW  same semantics for port B
b_gnt  out  1  access for B issued this cycle
b_rvalid  out  1  read data for B valid this cycle
b_rdata  out  DW  read data for B
mem_we  out  1  data memory write enable
mem_addr  out  AW  data memory address
mem_wdata  out  DW  data memory write data
mem_rdata  in  DW  data memory read data, valid one cycle after address issue

Behaviour:
- Reset (rst=0, async): wait_cnt=0, rd_own=NONE, a_rvalid=b_rvalid=0, a_rdata=b_rdata=0. While rst=0: a_gnt=b_gnt=0, mem_we=0, mem_addr=0, mem_wdata=0, a_stall=a_req.
- At most one access per cycle. Grants are combinational from current req and registered wait_cnt.
- Arbitration: force_b = b_req & (wait_cnt == MAX_WAIT). If force_b: b_gnt=1. Else if a_req: a_gnt=1. Else if b_req: b_gnt=1.
- Granted port drives mem_addr/mem_wdata; mem_we = granted port's we. With no grant: mem_we=0 and mem_addr/mem_wdata hold last values (no toggling).
- Requester holds req/we/addr/wdata stable until it samples gnt=1 at a rising edge; the access completes at that edge.
- wait_cnt: cleared on b_gnt; incremented (saturating at MAX_WAIT) when b_req & ~b_gnt; cleared when ~b_req.
- Writes complete in the grant cycle; no rvalid is generated for writes.
- Reads: rd_own registers the owner of a granted read (A, B, NONE). Next cycle the owner's rvalid=1 and its rdata is registered from mem_rdata, held until that port's next read returns. Back-to-back reads from alternating ports each produce rvalid in consecutive cycles with no bubble.
- a_stall is combinational; in a force_b cycle with a_req=1, a_stall=1 for exactly that cycle.
- Simultaneous a_req and b_req below the threshold: A wins; B counts.
- Reset asserted mid-read: the pending rvalid is dropped and no data is returned after reset releases.

Test Plan:
- Reset: hold rst=0 with a_req=b_req=1 -> a_gnt=b_gnt=0, mem_we=0, a_stall=1, all rvalid=0; release -> a_gnt=1 on the first edge.
- A read: a_req=1, a_we=0, a_addr=0x00010, memory holds 0x2AAAA -> a_gnt=1 in cycle 0; a_rvalid=1 and a_rdata=0x2AAAA in cycle 1; b_rvalid=0.
- A write then read: write 0x15555 to 0x00020, read 0x00020 next cycle -> mem_we=1 only in cycle 0; a_rdata=0x15555 in cycle 2.
- Starvation: a_req=1 and b_req=1 continuously, MAX_WAIT=4 -> b denied cycles 0-3, b_gnt=1 and a_stall=1 in cycle 4, a_gnt=1 in cycle 5; pattern repeats every 5 cycles.
- Alternating reads: A reads 0x1 (data 0x00111), B reads 0x2 (data 0x00222) in successive cycles -> a_rvalid in cycle 1 and b_rvalid in cycle 2 with correct data, no cross-delivery.
- Reset mid-read: grant a B read, assert rst=0 before the next edge -> b_rvalid stays 0 and b_rdata=0 after release.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Shares one data memory between the pipeline (port A, default priority) and a
// secondary requester (port B) that is force-granted after MAX_WAIT denied cycles.
module dmem_arbiter #(
    parameter int DW       = 22,
    parameter int AW       = 22,
    parameter int MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          a_req,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    output logic          a_gnt,
    output logic          a_stall,
    output logic          a_rvalid,
    output logic [DW-1:0] a_rdata,
    input  logic          b_req,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    output logic          b_gnt,
    output logic          b_rvalid,
    output logic [DW-1:0] b_rdata,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_A    = 2'd1,
        OWN_B    = 2'd2
    } rd_own_e;

    localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

    logic [3:0]    wait_cnt_q, wait_cnt_d;
    rd_own_e       rd_own_q, rd_own_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] a_rdata_q, a_rdata_d;
    logic [DW-1:0] b_rdata_q, b_rdata_d;
    logic          force_b;

    // Grants are held low while reset is asserted so the memory sees no access.
    always_comb begin
        force_b = b_req && (wait_cnt_q == WAIT_LIMIT);
        a_gnt   = 1'b0;
        b_gnt   = 1'b0;
        if (rst) begin
            if (force_b) begin
                b_gnt = 1'b1;
            end else if (a_req) begin
                a_gnt = 1'b1;
            end else if (b_req) begin
                b_gnt = 1'b1;
            end
        end
    end

    assign a_stall = a_req & ~a_gnt;

    always_comb begin
        mem_we     = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rd_own_d   = OWN_NONE;
        wait_cnt_d = wait_cnt_q;
        if (a_gnt) begin
            mem_we  = a_we;
            addr_d  = a_addr;
            wdata_d = a_wdata;
            if (!a_we) rd_own_d = OWN_A;
        end else if (b_gnt) begin
            mem_we  = b_we;
            addr_d  = b_addr;
            wdata_d = b_wdata;
            if (!b_we) rd_own_d = OWN_B;
        end
        if (!b_req || b_gnt) begin
            wait_cnt_d = 4'd0;
        end else if (wait_cnt_q != WAIT_LIMIT) begin
            wait_cnt_d = wait_cnt_q + 4'd1;
        end
    end

    // Idle cycles replay the last address/data so the memory bus does not toggle.
    assign mem_addr  = addr_d;
    assign mem_wdata = wdata_d;

    always_comb begin
        a_rdata_d = a_rdata_q;
        b_rdata_d = b_rdata_q;
        if (rd_own_q == OWN_A) a_rdata_d = mem_rdata;
        if (rd_own_q == OWN_B) b_rdata_d = mem_rdata;
    end

    assign a_rvalid = (rd_own_q == OWN_A);
    assign b_rvalid = (rd_own_q == OWN_B);
    assign a_rdata  = a_rdata_d;
    assign b_rdata  = b_rdata_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt_q <= 4'd0;
            rd_own_q   <= OWN_NONE;
            addr_q     <= '0;
            wdata_q    <= '0;
            a_rdata_q  <= '0;
            b_rdata_q  <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            rd_own_q   <= rd_own_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            a_rdata_q  <= a_rdata_d;
            b_rdata_q  <= b_rdata_d;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed vector table, hand-written corner sequences,
// then random traffic checked against a transaction-level reference model.
module tb_dmem_arbiter;

    localparam int DW       = 22;
    localparam int AW       = 22;
    localparam int MAX_WAIT = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          a_req = 1'b0, a_we = 1'b0;
    logic [AW-1:0] a_addr = '0;
    logic [DW-1:0] a_wdata = '0;
    logic          b_req = 1'b0, b_we = 1'b0;
    logic [AW-1:0] b_addr = '0;
    logic [DW-1:0] b_wdata = '0;
    logic          a_gnt, a_stall, a_rvalid, b_gnt, b_rvalid, mem_we;
    logic [DW-1:0] a_rdata, b_rdata, mem_wdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata = '0;

    logic [DW-1:0] mem [0:255];
    logic [DW-1:0] ref_mem [0:255];

    int checks = 0;
    int errors = 0;

    dmem_arbiter #(.DW(DW), .AW(AW), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_stall(a_stall), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous-read memory: data appears the cycle after the address.
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
        mem_rdata <= mem[mem_addr[7:0]];
    end

    typedef struct {
        logic          a_req, a_we;
        logic [AW-1:0] a_addr;
        logic [DW-1:0] a_wdata;
        logic          b_req, b_we;
        logic [AW-1:0] b_addr;
        logic [DW-1:0] b_wdata;
        logic          e_a_gnt, e_b_gnt, e_a_stall, e_mem_we;
        logic [AW-1:0] e_mem_addr;
        logic          e_a_rvalid;
        logic [DW-1:0] e_a_rdata;
        logic          e_b_rvalid;
        logic [DW-1:0] e_b_rdata;
    } vec_t;

    vec_t tbl [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive_idle();
        a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
        b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Reference model state
    int            m_wait, m_own;
    logic [DW-1:0] m_own_data, m_a_hold, m_b_hold, m_last_wdata;
    logic [AW-1:0] m_last_addr;

    task automatic gen_port(output logic req, output logic we, output logic [AW-1:0] addr,
                            output logic [DW-1:0] wdata, input int pct);
        req   = ($urandom_range(0, 99) < pct);
        we    = ($urandom_range(0, 2) == 0);
        addr  = AW'($urandom);
        wdata = DW'($urandom);
    endtask

    initial begin
        logic e_a, e_b, e_we, was_a, was_b;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wdata;
        int idx;

        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[8'h10] = 22'h2AAAA;
        mem[8'h01] = 22'h00111;
        mem[8'h02] = 22'h00222;

        tbl[0]  = '{1'b1,1'b0,22'h10,22'h0,     1'b0,1'b0,22'h0,22'h0,  1'b1,1'b0,1'b0,1'b0,22'h10, 1'b0,22'h0,     1'b0,22'h0};
        tbl[1]  = '{1'b1,1'b1,22'h20,22'h15555, 1'b0,1'b0,22'h0,22'h0,  1'b1,1'b0,1'b0,1'b1,22'h20, 1'b1,22'h2AAAA, 1'b0,22'h0};
        tbl[2]  = '{1'b1,1'b0,22'h20,22'h0,     1'b0,1'b0,22'h0,22'h0,  1'b1,1'b0,1'b0,1'b0,22'h20, 1'b0,22'h2AAAA, 1'b0,22'h0};
        tbl[3]  = '{1'b1,1'b0,22'h01,22'h0,     1'b0,1'b0,22'h0,22'h0,  1'b1,1'b0,1'b0,1'b0,22'h01, 1'b1,22'h15555, 1'b0,22'h0};
        tbl[4]  = '{1'b0,1'b0,22'h0,22'h0,      1'b1,1'b0,22'h02,22'h0, 1'b0,1'b1,1'b0,1'b0,22'h02, 1'b1,22'h00111, 1'b0,22'h0};
        tbl[5]  = '{1'b0,1'b0,22'h0,22'h0,      1'b0,1'b0,22'h0,22'h0,  1'b0,1'b0,1'b0,1'b0,22'h02, 1'b0,22'h00111, 1'b1,22'h00222};
        tbl[6]  = '{1'b0,1'b0,22'h0,22'h0,      1'b0,1'b0,22'h0,22'h0,  1'b0,1'b0,1'b0,1'b0,22'h02, 1'b0,22'h00111, 1'b0,22'h00222};
        tbl[7]  = '{1'b0,1'b0,22'h0,22'h0,      1'b1,1'b1,22'h30,22'h3F0F0, 1'b0,1'b1,1'b0,1'b1,22'h30, 1'b0,22'h00111, 1'b0,22'h00222};
        tbl[8]  = '{1'b1,1'b1,22'h31,22'h1,     1'b1,1'b0,22'h30,22'h0, 1'b1,1'b0,1'b0,1'b1,22'h31, 1'b0,22'h00111, 1'b0,22'h00222};
        tbl[9]  = '{1'b0,1'b0,22'h0,22'h0,      1'b1,1'b0,22'h30,22'h0, 1'b0,1'b1,1'b0,1'b0,22'h30, 1'b0,22'h00111, 1'b0,22'h00222};
        tbl[10] = '{1'b0,1'b0,22'h0,22'h0,      1'b0,1'b0,22'h0,22'h0,  1'b0,1'b0,1'b0,1'b0,22'h30, 1'b0,22'h00111, 1'b1,22'h3F0F0};

        // Reset held with both ports requesting
        rst = 1'b0; a_req = 1'b1; b_req = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_a_gnt", 32'(a_gnt), 32'd0);
        chk("rst_b_gnt", 32'(b_gnt), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_a_stall", 32'(a_stall), 32'd1);
        chk("rst_a_rvalid", 32'(a_rvalid), 32'd0);
        chk("rst_b_rvalid", 32'(b_rvalid), 32'd0);
        chk("rst_a_rdata", 32'(a_rdata), 32'd0);
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        chk("rel_a_gnt", 32'(a_gnt), 32'd1);
        chk("rel_b_gnt", 32'(b_gnt), 32'd0);
        next_cycle();
        drive_idle();
        @(negedge clk);
        chk("rel_a_rvalid", 32'(a_rvalid), 32'd1);
        next_cycle();

        // Directed vector table
        for (int i = 0; i < 11; i++) begin
            a_req = tbl[i].a_req; a_we = tbl[i].a_we; a_addr = tbl[i].a_addr; a_wdata = tbl[i].a_wdata;
            b_req = tbl[i].b_req; b_we = tbl[i].b_we; b_addr = tbl[i].b_addr; b_wdata = tbl[i].b_wdata;
            @(negedge clk);
            chk($sformatf("v%0d_a_gnt", i), 32'(a_gnt), 32'(tbl[i].e_a_gnt));
            chk($sformatf("v%0d_b_gnt", i), 32'(b_gnt), 32'(tbl[i].e_b_gnt));
            chk($sformatf("v%0d_a_stall", i), 32'(a_stall), 32'(tbl[i].e_a_stall));
            chk($sformatf("v%0d_mem_we", i), 32'(mem_we), 32'(tbl[i].e_mem_we));
            chk($sformatf("v%0d_mem_addr", i), 32'(mem_addr), 32'(tbl[i].e_mem_addr));
            chk($sformatf("v%0d_a_rvalid", i), 32'(a_rvalid), 32'(tbl[i].e_a_rvalid));
            chk($sformatf("v%0d_a_rdata", i), 32'(a_rdata), 32'(tbl[i].e_a_rdata));
            chk($sformatf("v%0d_b_rvalid", i), 32'(b_rvalid), 32'(tbl[i].e_b_rvalid));
            chk($sformatf("v%0d_b_rdata", i), 32'(b_rdata), 32'(tbl[i].e_b_rdata));
            next_cycle();
        end

        // Starvation: both ports request continuously; B forced every 5th cycle
        a_req = 1'b1; a_we = 1'b0; a_addr = 22'h01;
        b_req = 1'b1; b_we = 1'b0; b_addr = 22'h02;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk($sformatf("starve%0d_b_gnt", c), 32'(b_gnt), 32'((c % 5) == 4));
            chk($sformatf("starve%0d_a_gnt", c), 32'(a_gnt), 32'((c % 5) != 4));
            chk($sformatf("starve%0d_a_stall", c), 32'(a_stall), 32'((c % 5) == 4));
            next_cycle();
        end
        drive_idle();
        next_cycle();

        // Reset asserted while a B read is in flight
        b_req = 1'b1; b_we = 1'b0; b_addr = 22'h02;
        @(negedge clk);
        chk("midrd_b_gnt", 32'(b_gnt), 32'd1);
        #2 rst = 1'b0;
        next_cycle();
        drive_idle();
        @(negedge clk);
        chk("midrd_rst_b_rvalid", 32'(b_rvalid), 32'd0);
        chk("midrd_rst_b_rdata", 32'(b_rdata), 32'd0);
        next_cycle();
        rst = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk($sformatf("midrd%0d_b_rvalid", c), 32'(b_rvalid), 32'd0);
            chk($sformatf("midrd%0d_b_rdata", c), 32'(b_rdata), 32'd0);
            chk($sformatf("midrd%0d_a_rdata", c), 32'(a_rdata), 32'd0);
            next_cycle();
        end

        // Random traffic against the reference model
        for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
        m_wait = 0; m_own = 0; m_own_data = '0; m_a_hold = '0; m_b_hold = '0;
        m_last_addr = '0; m_last_wdata = '0;
        was_a = 1'b1; was_b = 1'b1;
        for (int c = 0; c < 400; c++) begin
            if (!a_req || was_a) gen_port(a_req, a_we, a_addr, a_wdata, 75);
            if (!b_req || was_b) gen_port(b_req, b_we, b_addr, b_wdata, 50);
            e_b = b_req && ((m_wait >= MAX_WAIT) || !a_req);
            e_a = a_req && !e_b;
            e_we    = e_a ? a_we : (e_b ? b_we : 1'b0);
            e_addr  = e_a ? a_addr : (e_b ? b_addr : m_last_addr);
            e_wdata = e_a ? a_wdata : (e_b ? b_wdata : m_last_wdata);
            @(negedge clk);
            chk("rnd_a_gnt", 32'(a_gnt), 32'(e_a));
            chk("rnd_b_gnt", 32'(b_gnt), 32'(e_b));
            chk("rnd_a_stall", 32'(a_stall), 32'(a_req && !e_a));
            chk("rnd_mem_we", 32'(mem_we), 32'(e_we));
            chk("rnd_mem_addr", 32'(mem_addr), 32'(e_addr));
            chk("rnd_mem_wdata", 32'(mem_wdata), 32'(e_wdata));
            chk("rnd_a_rvalid", 32'(a_rvalid), 32'(m_own == 1));
            chk("rnd_b_rvalid", 32'(b_rvalid), 32'(m_own == 2));
            chk("rnd_a_rdata", 32'(a_rdata), 32'((m_own == 1) ? m_own_data : m_a_hold));
            chk("rnd_b_rdata", 32'(b_rdata), 32'((m_own == 2) ? m_own_data : m_b_hold));
            next_cycle();
            if (m_own == 1) m_a_hold = m_own_data;
            if (m_own == 2) m_b_hold = m_own_data;
            m_own = 0;
            if (e_a || e_b) begin
                idx = int'(e_addr[7:0]);
                m_last_addr  = e_addr;
                m_last_wdata = e_wdata;
                if (e_we) ref_mem[idx] = e_wdata;
                else begin
                    m_own      = e_a ? 1 : 2;
                    m_own_data = ref_mem[idx];
                end
            end
            m_wait = (b_req && !e_b) ? ((m_wait < MAX_WAIT) ? m_wait + 1 : MAX_WAIT) : 0;
            was_a = e_a;
            was_b = e_b;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
